// File: rtl/fir_coeff_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : fir_coeff_loader                                          |
// | Streams 16-bit coefficients into the FIR coefficient RAM, framed   |
// | by the update flag. COEFF_READBACK_EN adds a read-back checksum.   |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module fir_coeff_loader #(
  parameter int NUM_BANKS     = 4,
  parameter int TAPS_PER_BANK = 10,
  parameter int PRE_CYC       = 2,
  parameter int POST_CYC      = 2
) (
  input  logic        iClk12M,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeffData,
`ifdef COEFF_READBACK_EN
  input  logic [15:0] iRdDtRam,
  output logic        oVerifyErr,
`endif
  output logic        oCoeffReady,
  output logic        oCoeffUpdateFlag,
  output logic        oCsnRam,
  output logic        oWrnRam,
  output logic [5:0]  oAddrRam,
  output logic [15:0] oWtDtRam,
  output logic        oBusy,
  output logic        oDone
);

  localparam logic [1:0] c_last_bank = 2'(NUM_BANKS - 1);
  localparam logic [3:0] c_last_tap  = 4'(TAPS_PER_BANK - 1);
  localparam logic [7:0] c_pre_last  = 8'(PRE_CYC - 1);
  localparam logic [7:0] c_post_last = 8'(POST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_POST  = 3'd4,
    S_DONE  = 3'd5
`ifdef COEFF_READBACK_EN
    , S_READ = 3'd6
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [1:0]  bank_q;
  logic [3:0]  tap_q;
  logic        flag_q, ready_q, csn_q, wrn_q, busy_q, done_q;
  logic [5:0]  addr_q;
  logic [15:0] wdata_q;

  logic w_start, w_xfer, w_issue, w_last_addr, w_clr_ctr;

`ifdef COEFF_READBACK_EN
  logic        rd_phase_q;
  logic [15:0] wsum_q, rsum_q;
  logic        verr_q;
  logic        w_rd_issue;
`endif

  assign w_start     = (state_q == S_IDLE) && (state_d == S_PRE);
  assign w_xfer      = (state_q == S_WAIT) && ready_q && iCoeffValid && !iAbort;
  assign w_last_addr = (addr_q == {c_last_bank, c_last_tap});
  // Counters restart at every load, every abort and before the read-back pass.
  assign w_clr_ctr   = (state_d == S_IDLE) || w_start ||
                       ((state_q == S_WRITE) && (state_d == S_POST));

`ifdef COEFF_READBACK_EN
  assign w_rd_issue = (state_d == S_READ) &&
                      ((state_q == S_POST) || ((state_q == S_READ) && rd_phase_q));
  assign w_issue    = w_xfer || w_rd_issue;
`else
  assign w_issue    = w_xfer;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = S_PRE;
      S_PRE:   if (cnt_q == c_pre_last) state_d = S_WAIT;
      S_WAIT:  if (w_xfer) state_d = S_WRITE;
      S_WRITE: state_d = w_last_addr ? S_POST : S_WAIT;
      S_POST: begin
        if (cnt_q == c_post_last) begin
`ifdef COEFF_READBACK_EN
          state_d = S_READ;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef COEFF_READBACK_EN
      S_READ:  if (rd_phase_q && w_last_addr) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (iAbort) state_d = S_IDLE;
  end

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      tap_q   <= '0;
      flag_q  <= 1'b0;
      ready_q <= 1'b0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COEFF_READBACK_EN
      rd_phase_q <= 1'b0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      verr_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      flag_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      ready_q <= (state_d == S_WAIT);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      csn_q   <= !w_issue;
      wrn_q   <= !w_xfer;
      cnt_q   <= ((state_d == state_q) && ((state_q == S_PRE) || (state_q == S_POST)))
                 ? cnt_q + 8'd1 : 8'd0;

      if (w_issue) begin
        addr_q <= {bank_q, tap_q};
        if (tap_q == c_last_tap) begin
          tap_q  <= '0;
          bank_q <= bank_q + 2'd1;
        end else begin
          tap_q  <= tap_q + 4'd1;
        end
      end
      if (w_xfer) wdata_q <= iCoeffData;
      if (w_clr_ctr) begin
        bank_q <= '0;
        tap_q  <= '0;
      end

`ifdef COEFF_READBACK_EN
      rd_phase_q <= (state_q == S_READ) ? !rd_phase_q : 1'b0;
      if (w_start) begin
        wsum_q <= '0;
        rsum_q <= '0;
        verr_q <= 1'b0;
      end
      if (w_xfer) wsum_q <= wsum_q + iCoeffData;
      // Read data arrives in the gap cycle that follows each read strobe.
      if ((state_q == S_READ) && rd_phase_q) begin
        rsum_q <= rsum_q + iRdDtRam;
        if (state_d == S_DONE) verr_q <= ((rsum_q + iRdDtRam) != wsum_q);
      end
`endif
    end
  end

  assign oCoeffReady      = ready_q;
  assign oCoeffUpdateFlag = flag_q;
  assign oCsnRam          = csn_q;
  assign oWrnRam          = wrn_q;
  assign oAddrRam         = addr_q;
  assign oWtDtRam         = wdata_q;
  assign oBusy            = busy_q;
  assign oDone            = done_q;
`ifdef COEFF_READBACK_EN
  assign oVerifyErr       = verr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : tb_fir_coeff_loader                                       |
// | Directed bench for fir_coeff_loader with a transaction-level model |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_fir_coeff_loader;

  localparam int NB    = 4;
  localparam int NT    = 10;
  localparam int PRE   = 2;
  localparam int POST  = 2;
  localparam int TOTAL = NB * NT;
`ifdef COEFF_READBACK_EN
  localparam int EXP_FALL = POST + 1 + 2 * TOTAL;
`else
  localparam int EXP_FALL = POST + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        ready, flag, csn, wrn, busy, done;
  logic [5:0]  addr;
  logic [15:0] wdt;
`ifdef COEFF_READBACK_EN
  logic [15:0] rd_dt = 16'h0000;
  logic        verr;
  logic [15:0] mem [64];
  bit          corrupt = 1'b0;
  int          rd_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;

  fir_coeff_loader #(
    .NUM_BANKS(NB), .TAPS_PER_BANK(NT), .PRE_CYC(PRE), .POST_CYC(POST)
  ) dut (
    .iClk12M(clk),
    .iRst(rst),
    .iStart(start),
    .iAbort(abort),
    .iCoeffValid(valid),
    .iCoeffData(data),
`ifdef COEFF_READBACK_EN
    .iRdDtRam(rd_dt),
    .oVerifyErr(verr),
`endif
    .oCoeffReady(ready),
    .oCoeffUpdateFlag(flag),
    .oCsnRam(csn),
    .oWrnRam(wrn),
    .oAddrRam(addr),
    .oWtDtRam(wdt),
    .oBusy(busy),
    .oDone(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Coefficient n lands at bank n/NT, tap n%NT.
  function automatic logic [5:0] exp_addr(input int n);
    return {2'(n / NT), 4'(n % NT)};
  endfunction

  // Model state: accepted coefficients of the current load and observed writes.
  int          m_n = 0;
  int          wr_cnt = 0, done_cnt = 0, cyc = 0;
  int          rise_cyc = -1, fall_cyc = -1, first_wr_cyc = -1, last_wr_cyc = -1;
  bit          pend = 1'b0;
  bit          mon_en = 1'b0;
  logic        flag_prev = 1'b0;
  logic [5:0]  pend_addr = '0;
  logic [15:0] pend_data = '0;
  logic [5:0]  log_addr[$];
  logic [15:0] log_data[$];

`ifdef COEFF_READBACK_EN
  always @(posedge clk) begin
    if (!csn && !wrn) mem[addr] <= wdt;
    if (!csn && wrn)  rd_dt <= mem[addr] ^ ((corrupt && addr == 6'h25) ? 16'h0040 : 16'h0000);
  end
`endif

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend      = 1'b0;
      flag_prev = 1'b0;
    end else if (mon_en) begin
      chk("wr_strobe", 32'(!csn && !wrn), 32'(pend));
      if (pend) begin
        chk("wr_addr", 32'(addr), 32'(pend_addr));
        chk("wr_data", 32'(wdt), 32'(pend_data));
      end
`ifdef COEFF_READBACK_EN
      if (!csn && wrn) begin
        chk("rd_addr", 32'(addr), 32'(exp_addr(rd_cnt)));
        rd_cnt++;
      end
`else
      chk("csn_eq_wrn", 32'(csn), 32'(wrn));
`endif
      if (!csn) chk("flag_in_access", 32'(flag), 32'd1);
      if (!csn) chk("ready_in_access", 32'(ready), 32'd0);
      if (ready) chk("ready_room", 32'(m_n < TOTAL), 32'd1);
      if (ready) chk("ready_flag", 32'(flag), 32'd1);
      if (done)  chk("done_busy_flag", 32'({busy, flag}), 32'h2);
      if (flag)  chk("busy_with_flag", 32'(busy), 32'd1);

      if (!csn && !wrn) begin
        log_addr.push_back(addr);
        log_data.push_back(wdt);
        wr_cnt++;
        if (wr_cnt == 1) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (flag && !flag_prev) rise_cyc = cyc;
      if (!flag && flag_prev) fall_cyc = cyc;
      flag_prev = flag;
      if (done) done_cnt++;

      pend = valid && ready && !abort;
      if (pend) begin
        pend_addr = exp_addr(m_n);
        pend_data = data;
        m_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_load();
    m_n = 0; wr_cnt = 0; done_cnt = 0;
    rise_cyc = -1; fall_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    log_addr.delete();
    log_data.delete();
`ifdef COEFF_READBACK_EN
    rd_cnt = 0;
`endif
  endtask

  task automatic run_load(input int gap_at, input int gap_len, input int restart_at,
                          input int abort_after);
    int acc = 0, gap = 0, c = 0;
    new_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (acc < TOTAL && c < 1000) begin
      if (acc == gap_at && gap < gap_len) begin
        valid = 1'b0;
        gap++;
      end else begin
        valid = 1'b1;
      end
      data  = 16'h0100 + 16'(acc);
      start = (c == restart_at);
      @(negedge clk);
      if (!valid) chk("gap_flag", 32'(flag), 32'd1);
      if (valid && ready) acc++;
      tick();
      c++;
      if (abort_after > 0 && acc == abort_after) break;
    end
    chk("feed_bound", 32'(c < 1000), 32'd1);
    valid = 1'b0;
    start = 1'b0;
    if (abort_after > 0) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic check_full(input string tag, input logic exp_err);
    chk({tag, "_writes"}, 32'(wr_cnt), 32'(TOTAL));
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_a0"}, 32'(log_addr[0]), 32'h00);
    chk({tag, "_d0"}, 32'(log_data[0]), 32'h0100);
    chk({tag, "_a9"}, 32'(log_addr[9]), 32'h09);
    chk({tag, "_a10"}, 32'(log_addr[10]), 32'h10);
    chk({tag, "_d10"}, 32'(log_data[10]), 32'h010A);
    chk({tag, "_a39"}, 32'(log_addr[39]), 32'h39);
    chk({tag, "_d39"}, 32'(log_data[39]), 32'h0127);
    chk({tag, "_flag_lead"}, 32'(first_wr_cyc - rise_cyc), 32'(PRE + 1));
    chk({tag, "_flag_lag"}, 32'(fall_cyc - last_wr_cyc), 32'(EXP_FALL));
`ifdef COEFF_READBACK_EN
    chk({tag, "_reads"}, 32'(rd_cnt), 32'(TOTAL));
    chk({tag, "_verr"}, 32'(verr), 32'(exp_err));
`else
    chk({tag, "_no_err_port"}, 32'(exp_err), 32'(done_cnt - 1));
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_csn",   32'(csn),   32'd1);
    chk("rst_wrn",   32'(wrn),   32'd1);
    chk("rst_addr",  32'(addr),  32'd0);
    chk("rst_data",  32'(wdt),   32'd0);
    chk("rst_flag",  32'(flag),  32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    #2 rst = 1'b0;
    mon_en = 1'b1;
    tick();

    run_load(-1, 0, -1, 0);
    wait_idle("full");
    check_full("full", 1'b0);

    run_load(10, 5, -1, 0);
    wait_idle("gap");
    check_full("gap", 1'b0);

    run_load(-1, 0, 4, 0);
    wait_idle("restart");
    check_full("restart", 1'b0);

`ifdef COEFF_READBACK_EN
    corrupt = 1'b1;
    run_load(-1, 0, -1, 0);
    wait_idle("corrupt");
    check_full("corrupt", 1'b1);
    corrupt = 1'b0;
`endif

    run_load(-1, 0, -1, 17);
    @(negedge clk);
    chk("abort_flag",  32'(flag),  32'd0);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    repeat (5) tick();
    chk("abort_writes", 32'(wr_cnt), 32'd17);
    chk("abort_last_addr", 32'(log_addr[16]), 32'h16);
    chk("abort_last_data", 32'(log_data[16]), 32'h0110);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
`ifdef COEFF_READBACK_EN
    chk("abort_verr_cleared", 32'(verr), 32'd0);
`endif
    run_load(-1, 0, -1, 0);
    wait_idle("after_abort");
    check_full("after_abort", 1'b0);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_flag", 32'(flag), 32'd0);
    tick();

    new_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    data  = 16'h0155;
    @(negedge clk);
    for (int i = 0; i < 50 && !(!csn && !wrn); i++) @(negedge clk);
    chk("rst_saw_write", 32'(!csn && !wrn), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_csn",  32'(csn),  32'd1);
    chk("arst_wrn",  32'(wrn),  32'd1);
    chk("arst_flag", 32'(flag), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_flag", 32'(flag), 32'd0);
    chk("post_rst_csn",  32'(csn),  32'd1);
    valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
